// File: rtl/resp_compactor.sv
// resp_compactor: buffers response beats in a small FIFO and folds them into a
// MISR signature, counting compacted beats, until the last beat of a run drains.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   start    - pulse that opens a new capture run (honoured in idle/done only)
//   in_valid - beat offered
//   in_ready - beat can be taken (run state, buffer not full)
//   in_data  - beat payload
//   in_last  - marks the final beat of the run
//   comp_en  - compaction enable; low stalls the MISR
//   sig      - MISR signature
//   count    - compacted beat count, saturating
//   sat      - sticky count-saturated flag
//   done     - run complete, sig/count frozen
module resp_compactor #(
  parameter int unsigned      WIDTH = 30,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 30'h00000053,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             comp_en,
  output logic [WIDTH-1:0] sig,
  output logic [15:0]      count,
  output logic             sat,
  output logic             done
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [15:0]      count_q, count_d;
  logic             sat_q, sat_d;
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             empty, full, one_left, accept, comp;
  logic [AW:0]      occupancy;
  logic [WIDTH-1:0] head, sig_step;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign one_left  = (occupancy == {{AW{1'b0}}, 1'b1});

  assign in_ready = (state_q == StRun) && !full;
  assign accept   = in_valid && in_ready;
  assign comp     = !empty && comp_en && ((state_q == StRun) || (state_q == StDrain));

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign sig_step = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ head;

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    count_d  = count_q;
    sat_d    = sat_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, accept};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, comp};

    if (comp) begin
      sig_d = sig_step;
      if (count_q == 16'hFFFF) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + 16'd1;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          sig_d    = SEED;
          count_d  = '0;
          sat_d    = 1'b0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      StRun: begin
        if (accept && in_last) state_d = StDrain;
      end
      StDrain: begin
        // Done once the buffer is, or is about to become, empty.
        if (empty || (one_left && comp)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sig_q    <= SEED;
      count_q  <= '0;
      sat_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  assign sig   = sig_q;
  assign count = count_q;
  assign sat   = sat_q;
  assign done  = (state_q == StDone);

endmodule

// File: tb/tb_resp_compactor.sv
// Directed bench for resp_compactor: table of short runs plus hand sequences for
// back-pressure, mid-run reset and start-in-run.
module tb_resp_compactor;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, comp_en;
  logic        in_ready, sat, done;
  logic [29:0] in_data, sig;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  resp_compactor dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_last (in_last),
    .comp_en (comp_en),
    .sig     (sig),
    .count   (count),
    .sat     (sat),
    .done    (done)
  );

  typedef struct {
    int          n;
    logic [29:0] d0;
    logic [29:0] d1;
    logic [29:0] exp_sig;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [29:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  logic [29:0] beats6[6];
  int          idx;
  logic        ir;

  initial begin
    vecs[0] = '{1, 30'h0ABCDEF1, 30'h0,        30'h0ABCDEF1, 16'd1};
    vecs[1] = '{2, 30'h00000001, 30'h00000002, 30'h00000000, 16'd2};
    vecs[2] = '{2, 30'h20000000, 30'h00000000, 30'h00000053, 16'd2};
    vecs[3] = '{2, 30'h3FFFFFFF, 30'h00000000, 30'h3FFFFFAD, 16'd2};
    vecs[4] = '{2, 30'h0000000F, 30'h000000F0, 30'h000000EE, 16'd2};
    beats6  = '{30'd1, 30'd2, 30'd3, 30'd4, 30'd5, 30'd6};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; comp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sig", 32'(sig), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of short runs.
    for (int i = 0; i < 5; i++) begin
      pulse_start();
      chk("run_ready", 32'(in_ready), 32'd1);
      chk("run_count_clr", 32'(count), 32'd0);
      if (vecs[i].n == 1) begin
        send(vecs[i].d0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("lat_done", 32'(done), 32'd1);
      end else begin
        send(vecs[i].d0, 1'b0);
        send(vecs[i].d1, 1'b1);
        wait_done();
      end
      chk("vec_sig", 32'(sig), 32'(vecs[i].exp_sig));
      chk("vec_count", 32'(count), 32'(vecs[i].exp_cnt));
      chk("vec_sat", 32'(sat), 32'd0);
      chk("done_ready", 32'(in_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("hold_sig", 32'(sig), 32'(vecs[i].exp_sig));
      chk("hold_done", 32'(done), 32'd1);
    end

    // Back-pressure: stall compaction, offer six beats, only four fit.
    comp_en = 1'b0;
    pulse_start();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = beats6[idx];
      in_last  = (idx == 5);
      ir = in_ready;
      @(posedge clk);
      if (ir) idx++;
      @(negedge clk);
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_count_stall", 32'(count), 32'd0);
    comp_en  = 1'b1;
    in_data  = beats6[idx];
    @(negedge clk);
    chk("bp_ready_rise", 32'(in_ready), 32'd1);
    for (int c = 0; c < 20 && idx < 6; c++) begin
      in_valid = 1'b1;
      in_data  = beats6[idx];
      in_last  = (idx == 5);
      ir = in_ready;
      @(posedge clk);
      if (ir) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_all_sent", 32'(idx), 32'd6);
    wait_done();
    chk("bp_sig", 32'(sig), 32'd4);
    chk("bp_count", 32'(count), 32'd6);

    // Mid-run reset discards buffered beats.
    comp_en = 1'b0;
    pulse_start();
    send(30'h111, 1'b0);
    send(30'h222, 1'b0);
    send(30'h333, 1'b0);
    chk("mr_ready_pre", 32'(in_ready), 32'd1);
    comp_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_sig", 32'(sig), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("mr_no_leftover", 32'(count), 32'd0);
    pulse_start();
    send(30'h5, 1'b1);
    wait_done();
    chk("mr_after_count", 32'(count), 32'd1);
    chk("mr_after_sig", 32'(sig), 32'h5);

    // Start in run is ignored.
    pulse_start();
    send(30'h100, 1'b0);
    @(negedge clk);
    pulse_start();
    chk("sir_count_mid", 32'(count), 32'd1);
    send(30'h3, 1'b1);
    wait_done();
    chk("sir_sig", 32'(sig), 32'h203);
    chk("sir_count", 32'(count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
